// File: rtl/controller_nios2e_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG take_action strobes and the CPU
// debug slave, using round-robin arbitration and a fixed IDLE/ACCESS/CAPTURE/DONE sequence.
module controller_nios2e_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // JTAG debug module side
  input  logic              jtag_addr_load,
  input  logic              jtag_rd,
  input  logic              jtag_wr,
  input  logic [37:0]       jdo,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  // CPU debug slave side
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  // debug RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_JTAG = 1'b1;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic [1:0]        state;
  logic              owner;
  logic              op_wr;
  logic              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [ADDR_W-1:0] jtag_addr;
  logic              jtag_pend;
  logic              jtag_op_wr;
  logic [DATA_W-1:0] jtag_wdata;

  logic [DATA_W-1:0] mon_dreg_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              monitor_error_q;

  logic cpu_req;
  logic jtag_cmd;
  logic jtag_done;
  logic jtag_busy;
  logic grant_any;
  logic grant_jtag;

  // jdo bits above the write-data field carry no meaning for this block.
  logic unused_jdo;
  assign unused_jdo = ^jdo[37:DATA_W+3];

  assign cpu_req   = cpu_read | cpu_write;
  assign jtag_cmd  = jtag_rd | jtag_wr;
  assign jtag_done = (state == ST_DONE) && (owner == OWN_JTAG);
  // A command landing on the completion cycle is accepted, since the slot frees now.
  assign jtag_busy = jtag_pend && !jtag_done;

  // Round-robin: on contention the requester that was not served last goes first.
  assign grant_any  = (state == ST_IDLE) && (jtag_pend || cpu_req);
  assign grant_jtag = jtag_pend && (!cpu_req || (last_grant == OWN_CPU));

  always_ff @(posedge clk) begin
    if (reset) begin
      jtag_addr       <= '0;
      jtag_pend       <= 1'b0;
      jtag_op_wr      <= 1'b0;
      jtag_wdata      <= '0;
      monitor_error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every register samples pre-edge values
      // regardless of statement order inside the block.
      if (jtag_addr_load) begin
        jtag_addr <= jdo[ADDR_W-1:0];
      end else if (jtag_done) begin
        jtag_addr <= jtag_addr + ADDR_ONE;
      end

      if (jtag_cmd && jtag_busy) begin
        monitor_error_q <= 1'b1;
      end else if (jtag_addr_load) begin
        monitor_error_q <= 1'b0;
      end

      if (jtag_cmd && !jtag_busy) begin
        jtag_pend  <= 1'b1;
        jtag_op_wr <= jtag_wr;
        jtag_wdata <= jdo[DATA_W+2:3];
      end else if (jtag_done) begin
        jtag_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      owner       <= OWN_CPU;
      op_wr       <= 1'b0;
      last_grant  <= OWN_CPU;
      addr_q      <= '0;
      wdata_q     <= '0;
      mon_dreg_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            state <= ST_ACCESS;
            if (grant_jtag) begin
              owner   <= OWN_JTAG;
              op_wr   <= jtag_op_wr;
              addr_q  <= jtag_addr;
              wdata_q <= jtag_wdata;
            end else begin
              owner   <= OWN_CPU;
              op_wr   <= cpu_write;
              addr_q  <= cpu_address;
              wdata_q <= cpu_writedata;
            end
          end
        end
        ST_ACCESS: begin
          state <= op_wr ? ST_DONE : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (owner == OWN_JTAG) begin
            mon_dreg_q <= ram_rdata;
          end else begin
            cpu_rdata_q <= ram_rdata;
          end
          state <= ST_DONE;
        end
        default: begin
          last_grant <= owner;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    ram_we          = 1'b0;
    ram_re          = 1'b0;
    monitor_ready   = 1'b0;
    cpu_waitrequest = cpu_req;
    if (state == ST_ACCESS) begin
      ram_we = op_wr;
      ram_re = !op_wr;
    end
    if (state == ST_DONE) begin
      if (owner == OWN_JTAG) begin
        monitor_ready = 1'b1;
      end else begin
        cpu_waitrequest = 1'b0;
      end
    end
  end

  assign ram_addr      = addr_q;
  assign ram_wdata     = wdata_q;
  assign MonDReg       = mon_dreg_q;
  assign cpu_readdata  = cpu_rdata_q;
  assign monitor_error = monitor_error_q;

endmodule

// File: tb/tb_controller_nios2e_ocimem_arbiter.sv
// Directed bench for the OCI memory arbiter: JTAG and CPU accesses, arbitration,
// address wrap, overrun detection and reset during an access, against a 1-cycle RAM model.
module tb_controller_nios2e_ocimem_arbiter;

  logic        clk;
  logic        reset;
  logic        jtag_addr_load;
  logic        jtag_rd;
  logic        jtag_wr;
  logic [37:0] jdo;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic        cpu_read;
  logic        cpu_write;
  logic [7:0]  cpu_address;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];

  controller_nios2e_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .jtag_addr_load  (jtag_addr_load),
    .jtag_rd         (jtag_rd),
    .jtag_wr         (jtag_wr),
    .jdo             (jdo),
    .MonDReg         (MonDReg),
    .monitor_ready   (monitor_ready),
    .monitor_error   (monitor_error),
    .cpu_read        (cpu_read),
    .cpu_write       (cpu_write),
    .cpu_address     (cpu_address),
    .cpu_writedata   (cpu_writedata),
    .cpu_readdata    (cpu_readdata),
    .cpu_waitrequest (cpu_waitrequest),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_we          (ram_we),
    .ram_re          (ram_re),
    .ram_rdata       (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_init(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // RAM model: contents reloaded on reset, read data one cycle after ram_re.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      n_checks++;
      if (ram_we && ram_re) begin
        n_fail++;
        $display("FAIL strobe_exclusive: ram_we=%b ram_re=%b, required not both 1", ram_we, ram_re);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  // Drives one CPU request from an IDLE cycle and observes it until waitrequest drops.
  task automatic run_cpu(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                         output int done_k, output logic [31:0] rdata, output int strobe_n,
                         output logic [7:0] strobe_addr, output logic [31:0] strobe_wdata);
    done_k = -1; strobe_n = 0; rdata = '0; strobe_addr = '0; strobe_wdata = '0;
    cpu_write = wr; cpu_read = !wr; cpu_address = addr; cpu_writedata = data;
    for (int k = 1; k <= 8 && done_k < 0; k++) begin
      tick;
      settle;
      if (ram_we || ram_re) begin
        strobe_n++;
        strobe_addr = ram_addr;
        strobe_wdata = ram_wdata;
      end
      if (!cpu_waitrequest) begin
        done_k = k;
        rdata = cpu_readdata;
      end
    end
    tick;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cpu_read = 1'b1;
    tick; tick;
    settle;
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    n_checks++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL reset_ram_re: got %b want 0", ram_re); end
    n_checks++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", monitor_ready); end
    n_checks++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", monitor_error); end
    n_checks++; if (MonDReg !== 32'h0) begin n_fail++; $display("FAIL reset_mondreg: got %h want 0", MonDReg); end
    n_checks++; if (cpu_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h want 0", cpu_readdata); end
    n_checks++; if (ram_addr !== 8'h0) begin n_fail++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
    n_checks++; if (cpu_waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_wait_held: got %b want 1", cpu_waitrequest); end
    tick;
    cpu_read = 1'b0;
    settle;
    n_checks++; if (cpu_waitrequest !== 1'b0) begin n_fail++; $display("FAIL reset_wait_idle: got %b want 0", cpu_waitrequest); end
    tick;
    reset = 1'b0;
  endtask

  task automatic test_jtag_write;
    int we_n = 0, rdy_n = 0, rdy_k = -1;
    logic [7:0]  we_addr = '0;
    logic [31:0] we_data = '0;
    jdo = 38'h05;
    jtag_addr_load = 1'b1;
    tick;
    jtag_addr_load = 1'b0;
    jdo = {3'b000, 32'hDEADBEEF, 3'b000};
    jtag_wr = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      jtag_wr = 1'b0;
      settle;
      if (ram_we) begin we_n++; we_addr = ram_addr; we_data = ram_wdata; end
      if (monitor_ready) begin rdy_n++; if (rdy_k < 0) rdy_k = k; end
    end
    n_checks++; if (we_n !== 1) begin n_fail++; $display("FAIL jwr_we_count: got %0d want 1", we_n); end
    n_checks++; if (we_addr !== 8'h05) begin n_fail++; $display("FAIL jwr_addr: got %h want 05", we_addr); end
    n_checks++; if (we_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL jwr_data: got %h want deadbeef", we_data); end
    n_checks++; if (rdy_k !== 3) begin n_fail++; $display("FAIL jwr_ready_cycle: got %0d want 3", rdy_k); end
    n_checks++; if (rdy_n !== 1) begin n_fail++; $display("FAIL jwr_ready_count: got %0d want 1", rdy_n); end
  endtask

  task automatic test_cpu_read;
    int done_k, strobe_n;
    logic [31:0] rdata, sw;
    logic [7:0]  sa;
    run_cpu(1'b0, 8'h05, 32'h0, done_k, rdata, strobe_n, sa, sw);
    n_checks++; if (done_k !== 3) begin n_fail++; $display("FAIL crd_latency: got %0d want 3", done_k); end
    n_checks++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL crd_data: got %h want deadbeef", rdata); end
    n_checks++; if (strobe_n !== 1 || sa !== 8'h05) begin n_fail++; $display("FAIL crd_strobe: got n=%0d addr=%h want n=1 addr=05", strobe_n, sa); end
  endtask

  task automatic test_arbitration;
    int re_n = 0, rdy_k = -1, done_k = -1;
    logic        cpu_drop = 1'b0;
    logic [7:0]  re_a0 = '0, re_a1 = '0;
    logic [31:0] mon = '0, rdata = '0;
    jtag_rd = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick;
      if (k == 1) begin
        jtag_rd = 1'b0;
        cpu_read = 1'b1;
        cpu_address = 8'h10;
      end
      if (cpu_drop) cpu_read = 1'b0;
      settle;
      if (ram_re) begin
        if (re_n == 0) re_a0 = ram_addr;
        else if (re_n == 1) re_a1 = ram_addr;
        re_n++;
      end
      if (monitor_ready && rdy_k < 0) begin rdy_k = k; mon = MonDReg; end
      if (cpu_read && !cpu_waitrequest && done_k < 0) begin
        done_k = k; rdata = cpu_readdata; cpu_drop = 1'b1;
      end
    end
    n_checks++; if (re_n !== 2 || re_a0 !== 8'h06 || re_a1 !== 8'h10) begin n_fail++; $display("FAIL arb_order: got n=%0d %h,%h want n=2 06,10", re_n, re_a0, re_a1); end
    n_checks++; if (rdy_k !== 4) begin n_fail++; $display("FAIL arb_jtag_cycle: got %0d want 4", rdy_k); end
    n_checks++; if (mon !== 32'hC0DE0006) begin n_fail++; $display("FAIL arb_mondreg: got %h want c0de0006", mon); end
    n_checks++; if (done_k !== 8) begin n_fail++; $display("FAIL arb_cpu_cycle: got %0d want 8", done_k); end
    n_checks++; if (rdata !== 32'hC0DE0010) begin n_fail++; $display("FAIL arb_cpu_data: got %h want c0de0010", rdata); end
  endtask

  task automatic test_wrap_overrun;
    int re_n = 0, rdy_n = 0, rdy_k = -1, err_k = -1;
    logic [7:0] re_a = '0;
    jdo = 38'hFF;
    jtag_addr_load = 1'b1;
    tick;
    jtag_addr_load = 1'b0;
    jtag_rd = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      jtag_rd = (k == 1);
      settle;
      if (ram_re) begin re_n++; re_a = ram_addr; end
      if (monitor_ready) begin rdy_n++; if (rdy_k < 0) rdy_k = k; end
      if (monitor_error && err_k < 0) err_k = k;
    end
    n_checks++; if (re_n !== 1 || re_a !== 8'hFF) begin n_fail++; $display("FAIL ovr_access: got n=%0d addr=%h want n=1 addr=ff", re_n, re_a); end
    n_checks++; if (rdy_n !== 1 || rdy_k !== 4) begin n_fail++; $display("FAIL ovr_ready: got n=%0d k=%0d want n=1 k=4", rdy_n, rdy_k); end
    n_checks++; if (MonDReg !== 32'hC0DE00FF) begin n_fail++; $display("FAIL ovr_mondreg: got %h want c0de00ff", MonDReg); end
    n_checks++; if (err_k !== 2) begin n_fail++; $display("FAIL ovr_error_cycle: got %0d want 2", err_k); end

    re_n = 0; rdy_k = -1;
    jtag_rd = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      jtag_rd = 1'b0;
      settle;
      if (ram_re) begin re_n++; re_a = ram_addr; end
      if (monitor_ready && rdy_k < 0) rdy_k = k;
    end
    n_checks++; if (re_n !== 1 || re_a !== 8'h00) begin n_fail++; $display("FAIL wrap_addr: got n=%0d addr=%h want n=1 addr=00", re_n, re_a); end
    n_checks++; if (MonDReg !== 32'hC0DE0000 || rdy_k !== 4) begin n_fail++; $display("FAIL wrap_read: got %h k=%0d want c0de0000 k=4", MonDReg, rdy_k); end
    n_checks++; if (monitor_error !== 1'b1) begin n_fail++; $display("FAIL error_sticky: got %b want 1", monitor_error); end

    jdo = 38'h20;
    jtag_addr_load = 1'b1;
    tick;
    jtag_addr_load = 1'b0;
    settle;
    n_checks++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL error_clear: got %b want 0", monitor_error); end
  endtask

  task automatic test_reset_mid_access;
    cpu_read = 1'b1;
    cpu_address = 8'h03;
    tick;
    settle;
    n_checks++; if (ram_re !== 1'b1 || ram_addr !== 8'h03) begin n_fail++; $display("FAIL rst_access: got re=%b addr=%h want re=1 addr=03", ram_re, ram_addr); end
    tick;
    reset = 1'b1;
    tick;
    settle;
    n_checks++; if (ram_re !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_strobes: got re=%b we=%b want 0,0", ram_re, ram_we); end
    n_checks++; if (dut.state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dut.state); end
    n_checks++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL rst_no_ready: got %b want 0", monitor_ready); end
    n_checks++; if (cpu_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_wait: got %b want 1", cpu_waitrequest); end
    n_checks++; if (cpu_readdata !== 32'h0) begin n_fail++; $display("FAIL rst_readdata: got %h want 0", cpu_readdata); end
    tick;
    settle;
    n_checks++; if (cpu_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_wait_hold: got %b want 1", cpu_waitrequest); end
    tick;
    cpu_read = 1'b0;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    int done_k, strobe_n;
    logic [31:0] rdata, sw;
    logic [7:0]  sa;
    run_cpu(1'b1, 8'h40, 32'h55AA_55AA, done_k, rdata, strobe_n, sa, sw);
    n_checks++; if (done_k !== 2) begin n_fail++; $display("FAIL b2b_wr0_latency: got %0d want 2", done_k); end
    n_checks++; if (strobe_n !== 1 || sa !== 8'h40 || sw !== 32'h55AA55AA) begin n_fail++; $display("FAIL b2b_wr0_strobe: got n=%0d %h %h want 1 40 55aa55aa", strobe_n, sa, sw); end
    run_cpu(1'b1, 8'h41, 32'h1234_5678, done_k, rdata, strobe_n, sa, sw);
    n_checks++; if (done_k !== 2 || sa !== 8'h41) begin n_fail++; $display("FAIL b2b_wr1: got k=%0d addr=%h want k=2 addr=41", done_k, sa); end
    run_cpu(1'b0, 8'h40, 32'h0, done_k, rdata, strobe_n, sa, sw);
    n_checks++; if (done_k !== 3 || rdata !== 32'h55AA55AA) begin n_fail++; $display("FAIL b2b_rd0: got k=%0d %h want k=3 55aa55aa", done_k, rdata); end
    run_cpu(1'b0, 8'h41, 32'h0, done_k, rdata, strobe_n, sa, sw);
    n_checks++; if (done_k !== 3 || rdata !== 32'h12345678) begin n_fail++; $display("FAIL b2b_rd1: got k=%0d %h want k=3 12345678", done_k, rdata); end
  endtask

  initial begin
    reset = 1'b1;
    jtag_addr_load = 1'b0;
    jtag_rd = 1'b0;
    jtag_wr = 1'b0;
    jdo = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_address = '0;
    cpu_writedata = '0;
    ram_rdata = '0;

    test_reset;
    test_jtag_write;
    test_cpu_read;
    test_arbitration;
    test_wrap_overrun;
    test_reset_mid_access;
    test_back_to_back;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
